// File: rtl/execute_stage.sv
// execute_stage: Y86-64 execute stage with ALU, condition codes, Cnd and halt/error latches
module execute_stage #(
  parameter int WIDTH = 64,
  parameter int STACK_STEP = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  output logic [WIDTH-1:0] valE,
  output logic             Cnd,
  output logic [2:0]       cc,
  output logic             halted,
  output logic             exe_error
);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);
  localparam logic [WIDTH-1:0] NEG_STEP = {WIDTH{1'b0}} - STEP;
  logic [WIDTH-1:0] aluA, aluB;
  logic [3:0] aluFun;
  logic zf, sf, of, lt, badInstr;
  // Operand muxes and ALU; flags are derived from the result for the CC update
  always_comb begin
    aluA = (icode == 4'h2 || icode == 4'h6) ? valA :
           (icode == 4'h3 || icode == 4'h4 || icode == 4'h5) ? valC :
           (icode == 4'h8 || icode == 4'hA) ? NEG_STEP :
           (icode == 4'h9 || icode == 4'hB) ? STEP : '0;
    aluB = (icode >= 4'h4 && icode <= 4'hB && icode != 4'h7) ? valB : '0;
    aluFun = (icode == 4'h6) ? ifun : 4'h0;
    valE = (aluFun == 4'h0) ? aluB + aluA :
           (aluFun == 4'h1) ? aluB - aluA :
           (aluFun == 4'h2) ? (aluB & aluA) :
           (aluFun == 4'h3) ? (aluB ^ aluA) : '0;
    zf = (valE == '0);
    sf = valE[MSB];
    of = (aluFun == 4'h0) ? (aluA[MSB] == aluB[MSB]) && (valE[MSB] != aluA[MSB]) :
         (aluFun == 4'h1) ? (aluA[MSB] != aluB[MSB]) && (valE[MSB] != aluB[MSB]) : 1'b0;
    badInstr = (icode > 4'hB) || (icode == 4'h6 && ifun > 4'h3) ||
               ((icode == 4'h2 || icode == 4'h7) && ifun > 4'h6);
  end
  // Branch/cmov condition from committed flags only
  always_comb begin
    lt = cc[1] ^ cc[0];
    Cnd = (icode != 4'h2 && icode != 4'h7) ? 1'b0 :
          (ifun == 4'h0) ? 1'b1 :
          (ifun == 4'h1) ? lt | cc[2] :
          (ifun == 4'h2) ? lt :
          (ifun == 4'h3) ? cc[2] :
          (ifun == 4'h4) ? ~cc[2] :
          (ifun == 4'h5) ? ~lt :
          (ifun == 4'h6) ? ~lt & ~cc[2] : 1'b0;
  end
  // Condition codes, halt and error latches; frozen once halted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cc <= 3'b100;
      halted <= 1'b0;
      exe_error <= 1'b0;
    end else if (instr_valid && !halted) begin
      if (icode == 4'h0) halted <= 1'b1;
      if (badInstr) exe_error <= 1'b1;
      else if (icode == 4'h6) cc <= {zf, sf, of};
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: scoreboard bench for execute_stage with directed vectors
module tb_execute_stage;
  logic clock = 1'b0, reset = 1'b0, instr_valid = 1'b0;
  logic [3:0] icode = 4'h1, ifun = 4'h0;
  logic [63:0] valA = '0, valB = '0, valC = '0, valE;
  logic Cnd, halted, exe_error;
  logic [2:0] cc;
  int checks = 0, failures = 0;
  typedef struct {
    string name;
    logic [63:0] valE;
    logic cnd;
    logic [2:0] cc;
    logic halted;
    logic err;
  } exp_t;
  exp_t sb[$];
  execute_stage #(.WIDTH(64), .STACK_STEP(8)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .icode(icode), .ifun(ifun),
    .valA(valA), .valB(valB), .valC(valC), .valE(valE), .Cnd(Cnd), .cc(cc),
    .halted(halted), .exe_error(exe_error)
  );
  always #5 clock = ~clock;
  task automatic cmp(string n, string f, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%h expected=%h", n, f, act, exp);
    end
  endtask
  // Monitor: compares DUT outputs on the falling edge against queued expectations
  always @(negedge clock) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.name, "valE", valE, e.valE);
      cmp(e.name, "Cnd", {63'b0, Cnd}, {63'b0, e.cnd});
      cmp(e.name, "cc", {61'b0, cc}, {61'b0, e.cc});
      cmp(e.name, "halted", {63'b0, halted}, {63'b0, e.halted});
      cmp(e.name, "exe_error", {63'b0, exe_error}, {63'b0, e.err});
    end
  end
  task automatic step(string n, logic r, logic v, logic [3:0] ic, logic [3:0] fn,
                      logic [63:0] a, logic [63:0] b, logic [63:0] c,
                      logic [63:0] eV, logic eC, logic [2:0] eCc, logic eH, logic eE);
    exp_t e;
    @(posedge clock);
    #1;
    reset = r; instr_valid = v; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    e.name = n; e.valE = eV; e.cnd = eC; e.cc = eCc; e.halted = eH; e.err = eE;
    sb.push_back(e);
  endtask
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M2 = 64'hFFFF_FFFF_FFFF_FFFE;
  initial begin
    step("rst",     0, 0, 4'h1, 4'h0, 0, 0, 0, 0, 0, 3'b100, 0, 0);
    step("jleRst",  1, 1, 4'h7, 4'h1, 0, 0, 0, 0, 1, 3'b100, 0, 0);
    step("add0",    1, 1, 4'h6, 4'h0, 1, '1, 0, 0, 0, 3'b100, 0, 0);
    step("ovf",     1, 1, 4'h6, 4'h0, MAXP, MAXP, 0, M2, 0, 3'b100, 0, 0);
    step("jl",      1, 1, 4'h7, 4'h2, 0, 0, 0, 0, 0, 3'b011, 0, 0);
    step("jle",     1, 1, 4'h7, 4'h1, 0, 0, 0, 0, 0, 3'b011, 0, 0);
    step("jne",     1, 1, 4'h7, 4'h4, 0, 0, 0, 0, 1, 3'b011, 0, 0);
    step("sub",     1, 1, 4'h6, 4'h1, 5, 3, 0, M2, 0, 3'b011, 0, 0);
    step("cmovl",   1, 1, 4'h2, 4'h2, 64'h55, 0, 0, 64'h55, 1, 3'b010, 0, 0);
    step("cmovg",   1, 1, 4'h2, 4'h6, 64'h55, 0, 0, 64'h55, 0, 3'b010, 0, 0);
    step("call",    1, 1, 4'h8, 4'h0, 0, 64'h100, 0, 64'hF8, 0, 3'b010, 0, 0);
    step("ret",     1, 1, 4'h9, 4'h0, 0, 64'hF8, 0, 64'h100, 0, 3'b010, 0, 0);
    step("mrmov",   1, 1, 4'h5, 4'h0, 0, 64'h20, 64'h10, 64'h30, 0, 3'b010, 0, 0);
    step("irmov",   1, 1, 4'h3, 4'h0, 0, 64'h99, 64'h1234, 64'h1234, 0, 3'b010, 0, 0);
    step("push",    1, 1, 4'hA, 4'h0, 0, 64'h100, 0, 64'hF8, 0, 3'b010, 0, 0);
    step("pop",     1, 1, 4'hB, 4'h0, 0, 64'hF8, 0, 64'h100, 0, 3'b010, 0, 0);
    step("badOp",   1, 1, 4'h6, 4'h7, 1, 1, 0, 0, 0, 3'b010, 0, 0);
    step("xor",     1, 1, 4'h6, 4'h3, 64'hF0, 64'hFF, 0, 64'h0F, 0, 3'b010, 0, 1);
    step("and",     1, 1, 4'h6, 4'h2, 64'hF0, 64'h0F, 0, 0, 0, 3'b000, 0, 1);
    step("badIcode",1, 1, 4'hC, 4'h0, 0, 0, 0, 0, 0, 3'b100, 0, 1);
    step("rst2",    0, 0, 4'h1, 4'h0, 0, 0, 0, 0, 0, 3'b100, 0, 0);
    step("noHalt",  1, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 3'b100, 0, 0);
    step("ovf2",    1, 1, 4'h6, 4'h0, MAXP, MAXP, 0, M2, 0, 3'b100, 0, 0);
    step("halt",    1, 1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 3'b011, 0, 0);
    step("opHalted",1, 1, 4'h6, 4'h1, 5, 3, 0, M2, 0, 3'b011, 1, 0);
    step("badHalted",1,1, 4'hD, 4'h0, 0, 0, 0, 0, 0, 3'b011, 1, 0);
    step("idle",    1, 0, 4'h1, 4'h0, 0, 0, 0, 0, 0, 3'b011, 1, 0);
    step("rst3",    0, 0, 4'h1, 4'h0, 0, 0, 0, 0, 0, 3'b100, 0, 0);
    step("release", 1, 0, 4'h1, 4'h0, 0, 0, 0, 0, 0, 3'b100, 0, 0);
    @(posedge clock);
    @(posedge clock);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
